// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//   General-purpose register file with a per-register busy scoreboard and a
//   sequential bulk-clear engine. It sits between the ALU result bus and the
//   operand muxes. Reads are combinational. An optional same-cycle
//   write-to-read bypass is controlled by BYPASS.
//
// Parameters
//   DATA_W    register width in bits
//   NUM_REGS  register count (power of two, >= 2); AW = $clog2(NUM_REGS)
//   BYPASS    1 = a write in this cycle is forwarded to matching read ports
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   writeEnable     write strobe; replaceSel / replaceData give address / data
//   A_sel, B_sel    read addresses
//   A, B            read data (combinational)
//   A_busy, B_busy  scoreboard flag of the addressed register (combinational)
//   reserveEnable   marks reserveSel busy (a pending result)
//   clearReq        starts the bulk clear (pulse or level)
//   clearBusy       high while the bulk clear runs (NUM_REGS cycles)
//   top_out         stored contents of register NUM_REGS-1 (never bypassed)
//
// Build option
//   REG_ZERO_HARDWIRE_EN  when defined, register 0 reads as constant zero with
//                         busy 0. Writes and reserves to it are discarded, and
//                         it is never bypassed. The clear engine still steps
//                         through index 0, so a clear takes the same time.
// ---------------------------------------------------------------------------
module register_file_sb #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeEnable,
  input  logic [AW-1:0]     replaceSel,
  input  logic [DATA_W-1:0] replaceData,
  input  logic [AW-1:0]     A_sel,
  input  logic [AW-1:0]     B_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_busy,
  output logic              B_busy,
  input  logic              reserveEnable,
  input  logic [AW-1:0]     reserveSel,
  input  logic              clearReq,
  output logic              clearBusy,
  output logic [DATA_W-1:0] top_out
);

`ifdef REG_ZERO_HARDWIRE_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;

  logic              idle;
  logic              wr_fire;
  logic              rs_fire;
  logic [DATA_W-1:0] entry_data [NUM_REGS];
  logic              entry_busy [NUM_REGS];

  assign idle      = (state_reg == IDLE);
  assign clearBusy = (state_reg == CLEAR);

  // Host strobes only act in IDLE. While a clear runs they are dropped, not
  // queued. With a hardwired zero register, index 0 never accepts them.
  assign wr_fire = idle && writeEnable && !(ZERO_HW && (replaceSel == '0));
  assign rs_fire = idle && reserveEnable && !(ZERO_HW && (reserveSel == '0));

  // -------------------------------------------------------------------------
  // Clear-engine FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clearReq) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        // The counter is AW bits wide, so it wraps back to 0 on the last
        // entry. That leaves IDLE ready for the next request.
        clr_cnt_next = clr_cnt_reg + AW'(1);
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage: one data word and one busy bit per entry
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      logic [DATA_W-1:0] data_reg;
      logic              busy_reg;
      logic              wr_hit;
      logic              rs_hit;
      logic              clr_hit;

      assign wr_hit  = wr_fire && (replaceSel == AW'(gi));
      assign rs_hit  = rs_fire && (reserveSel == AW'(gi));
      assign clr_hit = clearBusy && (clr_cnt_reg == AW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else if (clr_hit) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            data_reg <= replaceData;
          end
          // If a reserve and a write hit the same entry, the reserve wins.
          // The new producer is still pending.
          if (rs_hit) begin
            busy_reg <= 1'b1;
          end else if (wr_hit) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_busy[gi] = busy_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // A same-cycle reserve is deliberately not forwarded. Only the write is
  // forwarded, and the reserve shows up from the next cycle on.
  always_comb begin
    A      = entry_data[A_sel];
    A_busy = entry_busy[A_sel];
    B      = entry_data[B_sel];
    B_busy = entry_busy[B_sel];
    if ((BYPASS != 0) && wr_fire && (replaceSel == A_sel)) begin
      A      = replaceData;
      A_busy = 1'b0;
    end
    if ((BYPASS != 0) && wr_fire && (replaceSel == B_sel)) begin
      B      = replaceData;
      B_busy = 1'b0;
    end
    if (ZERO_HW && (A_sel == '0)) begin
      A      = '0;
      A_busy = 1'b0;
    end
    if (ZERO_HW && (B_sel == '0)) begin
      B      = '0;
      B_busy = 1'b0;
    end
  end

  assign top_out = entry_data[NUM_REGS-1];

endmodule
